mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Arbiter and byte sequencer that shares the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM). It accepts word-level requests from both, grants one at a time with MEM having priority, and serialises each access into 1, 2 or 4 little-endian byte cycles on the RAM port. It sits between the pipeline stages and the RAM/IO bus, and it owns every drive of ram_addr_o and ram_wr_o.

## Interface
- ADDR_W, 32, address width of requests and the RAM port.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset asserted).
- if_req_i  in  1  IF requests a 4-byte read; level, held until done.
- if_addr_i  in  ADDR_W  IF byte address.
- if_data_o  out  32  fetched word; valid in the if_done_o cycle, held until the next IF completion.
- if_done_o  out  1  one-cycle completion pulse for IF.
- mem_req_i  in  1  MEM requests an access; level, held until done.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_len_i  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- mem_addr_i  in  ADDR_W  MEM byte address; misaligned addresses are legal.
- mem_wdata_i  in  32  store data; byte k is bits [8k+7:8k].
- mem_rdata_o  out  32  load data, zero-extended; valid in the mem_done_o cycle, held until the next MEM load completion.
- mem_done_o  out  1  one-cycle completion pulse for MEM, for both loads and stores.
- ram_addr_o  out  ADDR_W  RAM byte address (registered).
- ram_wr_o  out  1  RAM write enable (registered).
- ram_dout_o  out  8  RAM write data (registered).
- ram_din_i  in  8  RAM read data. It is the byte at the ram_addr_o presented in the previous cycle.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: sample the requests.
  - mem_req_i high wins; otherwise if_req_i.
  - On a grant, latch the owner, we, address, length N (1/2/4) and wdata.
  - Go to READ or WRITE. Byte counter k = 0.
- READ: present ram_addr_o = base + k with ram_wr_o = 0 for k = 0..N-1.
  - Capture ram_din_i into byte k-1 of the assembly register each cycle after the first.
  - After the last address is presented, spend one extra cycle capturing byte N-1.
  - Then go to DONE.
- WRITE: present base + k, ram_wr_o = 1 and ram_dout_o = byte k for k = 0..N-1.
  - Then go to DONE with ram_wr_o = 0.
- DONE (one cycle):
  - Pulse the owner's done.
  - For a read, drive the owner's data output: assembled bytes, upper unused bytes 0.
  - ram_addr_o = 0. Next state is IDLE.
- Request inputs are ignored outside IDLE. Changes to address, data or length mid-transaction have no effect.
- A requester drops req in the cycle after its done pulse, unless it starts a new access. IDLE re-samples that cycle.
- Address arithmetic is modulo 2^ADDR_W: base 0xFFFFFFFF with N = 2 accesses 0xFFFFFFFF, then 0x0.
- Sign extension is not done here. The MEM stage applies it.

## Timing
- Reset (rst = 0 at an edge):
  - state = IDLE; all outputs 0.
  - Assembly register and held data outputs are cleared to 0.
  - Reset mid-transaction aborts it: no done pulse. Bytes already written stay written.
- Grant at edge E0 (IDLE with a request). Addresses occupy cycles E0+1 .. E0+N.
- Read: done in cycle E0+N+2, so latency from grant is N+2 cycles (byte 3, word 6).
- Write: done in cycle E0+N+1 (byte 2, word 5).
- Back-to-back: the earliest next grant is the IDLE cycle right after DONE. Each transaction has one idle bubble.
- Simultaneous requests in IDLE:
  - MEM is served first.
  - IF keeps its req high and is granted in the IDLE after MEM's DONE.
  - IF can starve while MEM requests continuously; the pipeline guarantees it does not.
- ram_addr_o is 0 and ram_wr_o is 0 in every cycle not listed above.

## Structure
- Shared package (`defines`) holds:
  - the length codes LEN_B/LEN_H/LEN_W;
  - state encodings;
  - ZeroWord;
  - the requester IDs OWN_IF/OWN_MEM.
- Sub-module `mem_byte_seq`: counter plus address/data byte-lane generator plus read assembler, driven by start, we, base and len, returning last and assembled data.
- The top level holds the arbiter and FSM.

## Test plan
- Byte store: mem_req = 1, we = 1, len = 0, addr = 0x100, wdata = 0xA5.
  - Response: one cycle with ram_addr 0x100, wr = 1, dout 0xA5; mem_done 2 cycles after grant.
- Word load, RAM[0x200..0x203] = 11 22 33 44.
  - Response: ram_addr steps 0x200..0x203; mem_rdata = 0x44332211 with mem_done 6 cycles after grant.
- Contention: if_req and mem_req (half load at 0x10, RAM = 0x80 0xFF) rise together.
  - Response: MEM done first with rdata 0x0000FF80; IF granted in the following IDLE and gets its word.
- Wrap: word store at 0xFFFFFFFE, wdata 0xDEADBEEF.
  - Response: writes EF@FFFFFFFE, BE@FFFFFFFF, AD@0, DE@1.
- Reset mid-load: drop rst during the third address cycle of an IF word fetch.
  - Response: no if_done; all outputs 0 next cycle; a fresh fetch then completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serialising RAM port controller:
// length codes, FSM states, requester IDs and the length decoder.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Length code 3 is an oversized request and is served as a word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the IF request, MEM request and byte-wide RAM port signals.
// The controller takes the slave side; the pipeline/RAM environment the master side.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [31:0]       if_data_o;
    logic              if_done_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_len_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_done_o;

    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_data_o, if_done_o,
        input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, mem_done_o,
        output ram_addr_o, ram_wr_o, ram_dout_o,
        input  ram_din_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_data_o, if_done_o,
        output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, mem_done_o,
        input  ram_addr_o, ram_wr_o, ram_dout_o,
        output ram_din_i
    );

endinterface

// File: rtl/mem_ctrl_byte_seq.sv
// Byte sequencer: per-transaction counter, address/data lane generator and
// read assembler. k counts edges since the grant; byte j is captured at k = j+2.
module mem_byte_seq
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              active_i,
    input  logic              we_i,
    input  logic [1:0]        len_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [31:0]       wdata_i,
    input  logic [7:0]        din_i,
    output logic [ADDR_W-1:0] lane_addr_o,
    output logic [7:0]        lane_byte_o,
    output logic              addr_phase_o,
    output logic              wr_last_o,
    output logic              rd_last_o,
    output logic [31:0]       asm_o
);

    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q;
    logic [2:0]        n_q;
    logic              we_q;
    logic [2:0]        k_q;
    logic [31:0]       asm_q;

    logic              cap_en;
    logic [1:0]        cap_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q  <= '0;
            wdata_q <= ZeroWord;
            n_q     <= 3'd0;
            we_q    <= 1'b0;
            k_q     <= 3'd0;
            asm_q   <= ZeroWord;
        end else if (start_i) begin
            base_q  <= base_i;
            wdata_q <= wdata_i;
            n_q     <= len_to_n(len_i);
            we_q    <= we_i;
            k_q     <= 3'd1;
            asm_q   <= ZeroWord;
        end else if (active_i) begin
            k_q <= k_q + 3'd1;
            if (cap_en) begin
                asm_q <= asm_o;
            end
        end
    end

    // RAM data lags its address by one cycle, so captures trail issue by two edges.
    assign cap_en  = active_i && !we_q && (k_q >= 3'd2);
    assign cap_idx = k_q[1:0] - 2'd2;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_o[8*gi +: 8] = (cap_en && (cap_idx == 2'(gi))) ? din_i
                                                                     : asm_q[8*gi +: 8];
        end
    endgenerate

    // On the grant edge the first lane comes straight from the request inputs.
    assign lane_addr_o  = start_i ? base_i : base_q + ADDR_W'(k_q);
    assign lane_byte_o  = start_i ? wdata_i[7:0] : wdata_q[{k_q[1:0], 3'b000} +: 8];
    assign addr_phase_o = (k_q < n_q);
    assign wr_last_o    = (k_q == n_q);
    assign rd_last_o    = (k_q == (n_q + 3'd1));

endmodule

// File: rtl/mem_ctrl.sv
// Shares the byte-wide RAM port between IF and MEM: MEM-priority arbiter,
// transaction FSM and registered RAM/response outputs around mem_byte_seq.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic     clk,
    input  logic     rst,
    mem_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wr_q, ram_wr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;

    logic              grant_mem;
    logic              grant_any;
    logic              grant_we;
    logic [1:0]        grant_len;
    logic [ADDR_W-1:0] grant_base;
    logic [31:0]       grant_wdata;
    logic              start;
    logic              active;

    logic [ADDR_W-1:0] lane_addr;
    logic [7:0]        lane_byte;
    logic              addr_phase;
    logic              wr_last;
    logic              rd_last;
    logic [31:0]       asm_word;

    // MEM wins any tie; IF always fetches a full word.
    always_comb begin
        grant_mem   = bus.mem_req_i;
        grant_any   = bus.mem_req_i || bus.if_req_i;
        grant_we    = grant_mem ? bus.mem_we_i    : 1'b0;
        grant_len   = grant_mem ? bus.mem_len_i   : LEN_W;
        grant_base  = grant_mem ? bus.mem_addr_i  : bus.if_addr_i;
        grant_wdata = grant_mem ? bus.mem_wdata_i : ZeroWord;
    end

    assign start  = (state_q == ST_IDLE) && grant_any;
    assign active = (state_q == ST_READ) || (state_q == ST_WRITE);

    mem_byte_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .active_i     (active),
        .we_i         (grant_we),
        .len_i        (grant_len),
        .base_i       (grant_base),
        .wdata_i      (grant_wdata),
        .din_i        (bus.ram_din_i),
        .lane_addr_o  (lane_addr),
        .lane_byte_o  (lane_byte),
        .addr_phase_o (addr_phase),
        .wr_last_o    (wr_last),
        .rd_last_o    (rd_last),
        .asm_o        (asm_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'h00;
            if_data_q   <= ZeroWord;
            mem_rdata_q <= ZeroWord;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    // The RAM port idles at address 0 / no write whenever nothing is issued.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ram_addr_d  = '0;
        ram_wr_d    = 1'b0;
        ram_dout_d  = 8'h00;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    owner_d    = grant_mem ? OWN_MEM : OWN_IF;
                    ram_addr_d = lane_addr;
                    if (grant_we) begin
                        ram_wr_d   = 1'b1;
                        ram_dout_d = lane_byte;
                        state_d    = ST_WRITE;
                    end else begin
                        state_d    = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (addr_phase) begin
                    ram_addr_d = lane_addr;
                end
                if (rd_last) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_MEM) begin
                        mem_rdata_d = asm_word;
                        mem_done_d  = 1'b1;
                    end else begin
                        if_data_d   = asm_word;
                        if_done_d   = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                if (addr_phase) begin
                    ram_addr_d = lane_addr;
                    ram_wr_d   = 1'b1;
                    ram_dout_d = lane_byte;
                end else if (wr_last) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_MEM) begin
                        mem_done_d = 1'b1;
                    end else begin
                        if_done_d  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ram_addr_o  = ram_addr_q;
    assign bus.ram_wr_o    = ram_wr_q;
    assign bus.ram_dout_o  = ram_dout_q;
    assign bus.if_data_o   = if_data_q;
    assign bus.if_done_o   = if_done_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.mem_done_o  = mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: vector table plus hand sequences, with a scoreboard of
// expected completions and RAM writes checked by a negedge monitor.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: 1 KiB aliased by addr[9:0]; read data lags the address a cycle.
    logic [7:0] ram_m [0:1023];
    logic       pl_we = 1'b0;
    logic [9:0] pl_a  = '0;
    logic [7:0] pl_d  = '0;

    always @(posedge clk) begin
        if (pl_we) ram_m[pl_a] <= pl_d;
        else if (bus.ram_wr_o) ram_m[bus.ram_addr_o[9:0]] <= bus.ram_dout_o;
        bus.ram_din_i <= ram_m[bus.ram_addr_o[9:0]];
    end

    typedef struct {
        logic        own;
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        own;
        logic        we;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int tb_n(input logic [1:0] l);
        return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
    endfunction

    task automatic preload(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ram_addr"},  bus.ram_addr_o,  0);
        chk({nm, "_ram_wr"},    bus.ram_wr_o,    0);
        chk({nm, "_ram_dout"},  bus.ram_dout_o,  0);
        chk({nm, "_if_data"},   bus.if_data_o,   0);
        chk({nm, "_if_done"},   bus.if_done_o,   0);
        chk({nm, "_mem_rdata"}, bus.mem_rdata_o, 0);
        chk({nm, "_mem_done"},  bus.mem_done_o,  0);
    endtask

    task automatic wait_done(input logic own);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = own ? (bus.mem_done_o === 1'b1) : (bus.if_done_o === 1'b1);
        end
        if (!seen) chk(own ? "timeout_mem_done" : "timeout_if_done", 0, 1);
    endtask

    task automatic do_req(input vec_t v);
        int n;
        n = tb_n(v.len);
        @(negedge clk);
        if (v.own) begin
            bus.mem_req_i   = 1'b1;
            bus.mem_we_i    = v.we;
            bus.mem_len_i   = v.len;
            bus.mem_addr_i  = v.addr;
            bus.mem_wdata_i = v.wdata;
        end else begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = v.addr;
        end
        exp_q.push_back('{v.own, v.we, v.exp, cyc + n + (v.we ? 1 : 2)});
        if (v.we) begin
            for (int i = 0; i < n; i++) wr_q.push_back('{v.addr + 32'(i), v.wdata[8*i +: 8]});
        end
        wait_done(v.own);
        if (v.own) bus.mem_req_i = 1'b0;
        else bus.if_req_i = 1'b0;
    endtask

    // Pops the scoreboard on every completion pulse and every RAM write.
    task automatic monitor();
        exp_t        e;
        wr_t         w;
        logic [31:0] last_load;
        last_load = 32'h0;
        forever begin
            @(negedge clk);
            if (rst == 1'b0) last_load = 32'h0;
            if (bus.mem_done_o === 1'b1 || bus.if_done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {bus.mem_done_o, bus.if_done_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_owner", {bus.mem_done_o, bus.if_done_o}, e.own ? 2'b10 : 2'b01);
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("done_port_idle", {bus.ram_wr_o, bus.ram_addr_o}, 0);
                    if (e.we) begin
                        chk("store_rdata_held", bus.mem_rdata_o, last_load);
                    end else if (e.own) begin
                        chk("mem_rdata", bus.mem_rdata_o, e.data);
                        last_load = e.data;
                    end else begin
                        chk("if_data", bus.if_data_o, e.data);
                    end
                    $display("done own=%0d we=%0d cycle=%0d data=%h", e.own, e.we, cyc,
                             e.own ? bus.mem_rdata_o : bus.if_data_o);
                end
            end
            if (bus.ram_wr_o === 1'b1) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", bus.ram_wr_o, 0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", bus.ram_addr_o, w.addr);
                    chk("wr_data", bus.ram_dout_o, w.data);
                    $display("write addr=%h data=%h", bus.ram_addr_o, bus.ram_dout_o);
                end
            end
        end
    endtask

    initial begin
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_len_i   = 2'd0;
        bus.mem_addr_i  = '0;
        bus.mem_wdata_i = '0;

        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        check_zero("reset");

        preload(10'h200, 8'h11); preload(10'h201, 8'h22);
        preload(10'h202, 8'h33); preload(10'h203, 8'h44);
        preload(10'h010, 8'h80); preload(10'h011, 8'hFF);
        preload(10'h303, 8'h77); preload(10'h304, 8'h66);
        preload(10'h204, 8'h01); preload(10'h205, 8'h02);
        preload(10'h206, 8'h03); preload(10'h207, 8'h04);
        @(negedge clk);
        rst = 1'b1;

        //          own   we    len    addr          wdata         expected read data
        vecs[0] = '{1'b1, 1'b1, 2'd0, 32'h0000_0100, 32'h0000_00A5, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,         32'h4433_2211};
        vecs[2] = '{1'b1, 1'b1, 2'd1, 32'h0000_0301, 32'h1234_BEEF, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0,         32'h0000_00BE};
        vecs[5] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_ADBE};
        vecs[6] = '{1'b0, 1'b0, 2'd2, 32'h0000_0301, 32'h0,         32'h6677_BEEF};
        vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h0000_0200, 32'h0,         32'h4433_2211};
        vecs[8] = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h0000_00A5};
        vecs[9] = '{1'b1, 1'b0, 2'd1, 32'h0000_0302, 32'h0,         32'h0000_77BE};

        for (int i = 0; i < 10; i++) do_req(vecs[i]);

        // Contention: MEM half load served first, IF fetch in the following IDLE.
        @(negedge clk);
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_len_i  = 2'd1;
        bus.mem_addr_i = 32'h0000_0010;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h0000_0200;
        exp_q.push_back('{1'b1, 1'b0, 32'h0000_FF80, cyc + 4});
        exp_q.push_back('{1'b0, 1'b0, 32'h4433_2211, cyc + 11});
        wait_done(1'b1);
        bus.mem_req_i = 1'b0;
        wait_done(1'b0);
        bus.if_req_i = 1'b0;

        // Reset during the third address cycle of an IF fetch aborts it silently.
        @(negedge clk);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0200;
        repeat (3) @(negedge clk);
        chk("abort_third_addr", bus.ram_addr_o, 32'h0000_0202);
        rst = 1'b0;
        bus.if_req_i = 1'b0;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        do_req('{1'b0, 1'b0, 2'd2, 32'h0000_0204, 32'h0, 32'h0403_0201});

        repeat (5) @(negedge clk);
        chk("pending_done_left", 64'(exp_q.size()), 0);
        chk("pending_write_left", 64'(wr_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
